// File: rtl/multi_tick_divider.sv
// Multi-channel tick generator: divides clk_12MHz into per-channel one-cycle strobes.
// Optional TICKGEN_SQUARE_EN adds a per-channel 50 % square-wave output (sq).
module multi_tick_divider #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 27,
  parameter logic [CHANNELS*CNT_W-1:0] DEF_DIV = {27'd2400, 27'd12000}
) (
  input  logic                clk_12MHz,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [2:0]          wr_chan,
  input  logic [CNT_W-1:0]    wr_div,
  output logic [CHANNELS-1:0] tick,
`ifdef TICKGEN_SQUARE_EN
  output logic [CHANNELS-1:0] sq,
`endif
  output logic                wr_err
);

  localparam logic [3:0] CH_LIM = 4'(CHANNELS);

  logic [CHANNELS-1:0][CNT_W-1:0] cnt, cnt_nx;
  logic [CHANNELS-1:0][CNT_W-1:0] div, div_nx;
  logic [CHANNELS-1:0][CNT_W-1:0] nxt, nxt_nx;
  logic [CHANNELS-1:0]            pend, pend_nx;
  logic [CHANNELS-1:0]            tick_nx;
  logic                           wr_ok;
  logic                           wr_rej;

  assign wr_ok  = wr_en && ({1'b0, wr_chan} < CH_LIM) && (wr_div != '0);
  assign wr_rej = wr_en && !wr_ok;

  always_comb begin
    logic hit;
    logic wrap;
    cnt_nx  = cnt;
    div_nx  = div;
    nxt_nx  = nxt;
    pend_nx = pend;
    tick_nx = '0;
    hit     = 1'b0;
    wrap    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit  = wr_ok && (wr_chan == 3'(i));
      wrap = (cnt[i] == div[i] - CNT_W'(1));
      if (sync || !en[i]) begin
        // Idle or realigning: no period in flight, so divisors land immediately.
        cnt_nx[i]  = '0;
        pend_nx[i] = 1'b0;
        if (pend[i]) div_nx[i] = nxt[i];
        if (hit) begin
          div_nx[i] = wr_div;
          nxt_nx[i] = wr_div;
        end
      end else if (wrap) begin
        cnt_nx[i]  = '0;
        tick_nx[i] = 1'b1;
        if (pend[i]) div_nx[i] = nxt[i];
        pend_nx[i] = hit;
        if (hit) nxt_nx[i] = wr_div;
      end else begin
        cnt_nx[i] = cnt[i] + CNT_W'(1);
        if (hit) begin
          nxt_nx[i]  = wr_div;
          pend_nx[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pend   <= '0;
      tick   <= '0;
      wr_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        div[i] <= DEF_DIV[i*CNT_W +: CNT_W];
        nxt[i] <= DEF_DIV[i*CNT_W +: CNT_W];
      end
    end else begin
      cnt    <= cnt_nx;
      div    <= div_nx;
      nxt    <= nxt_nx;
      pend   <= pend_nx;
      tick   <= tick_nx;
      wr_err <= wr_rej;
    end
  end

`ifdef TICKGEN_SQUARE_EN
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      sq <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        sq[i] <= (sync || !en[i]) ? 1'b0 : (sq[i] ^ tick[i]);
    end
  end
`endif

endmodule

// File: doc/multi_tick_divider.md
# multi_tick_divider

Parametrised multi-channel tick generator. Divides the 12 MHz system clock into CHANNELS independent one-cycle enable pulses. Each channel has a per-channel reset divisor and a divisor that can be reprogrammed at run time. New divisors are double-buffered so no period is ever truncated. It feeds scan, debounce and refresh logic with slow strobes from one shared block.

## Interface
- CHANNELS, 2: number of tick channels (1–8).
- CNT_W, 27: counter and divisor width.
- DEF_DIV, {27'd2400, 27'd12000}: packed CHANNELS×CNT_W reset divisors; slice i is channel i. Defaults give 1 kHz on ch0 and 5 kHz on ch1.
- clk_12MHz  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel run enable.
- sync  in  1  restart all channel counters together (phase alignment).
- wr_en  in  1  divisor write strobe.
- wr_chan  in  3  target channel index.
- wr_div  in  CNT_W  new divisor (valid range ≥1).
- tick  out  CHANNELS  registered one-cycle pulse per channel period.
- wr_err  out  1  registered one-cycle pulse when a write is rejected.

## Operation
- Per-channel state: cnt[i], active divisor div[i], shadow nxt[i], pending flag pend[i].
- Counting (en[i]=1, no sync):
  - If cnt[i]==div[i]−1: cnt←0 and tick[i]←1.
  - If pend[i] is set at that wrap: div←nxt and pend←0.
  - Otherwise: cnt←cnt+1 and tick[i]←0.
- div=1: tick held high continuously.
- Disabled (en[i]=0): cnt[i]←0 and tick[i]←0. Any pending divisor is applied immediately (div←nxt, pend←0).
- sync=1: every cnt←0 and every tick←0 in that cycle. All pending divisors are applied. sync overrides counting.
- Write, accepted if wr_chan<CHANNELS and wr_div≠0:
  - nxt[wr_chan]←wr_div and pend←1.
  - A later write before the wrap overwrites nxt; last write wins.
- Write, rejected if wr_chan≥CHANNELS or wr_div==0:
  - No state changes.
  - wr_err←1 for one cycle.
- Write in the same cycle as sync, or to a disabled channel: the written divisor becomes div directly. pend stays 0.
- Write to a channel in the same cycle that channel wraps: the old pend value is applied at this wrap. The new value is pending for the next wrap.
- Arithmetic: unsigned CNT_W bits. cnt never exceeds div−1, so no wrap beyond the terminal count.

## Timing
- Reset values: tick=0, wr_err=0, cnt=0, div[i]=DEF_DIV slice i, nxt=div, pend=0.
- With en[i]=1 from reset release, the first tick[i] is high after the div[i]-th rising edge. After that, the tick period is exactly div[i] cycles.
- tick and wr_err are registered, with no combinational path from any input.
- A rejected write produces wr_err one cycle after the wr_en edge.
- Deasserting rst_n mid-operation clears everything asynchronously. Any pending write is lost.
- After sync is released, the first tick is div cycles later on every enabled channel, so channels are phase-aligned.

## Configuration
- TICKGEN_SQUARE_EN defined:
  - Adds output sq (CHANNELS bits, reset 0).
  - sq[i] toggles on every cycle where tick[i] is 1, giving a 50 % square wave of period 2·div[i].
  - sq[i] is cleared by sync and while en[i]=0.
- TICKGEN_SQUARE_EN undefined: the sq port and its registers are absent. All other behaviour is identical.

## Test plan
- Reset defaults: en=2'b11 after reset → tick[0] every 12000 cycles and tick[1] every 2400 cycles, each high exactly 1 cycle. First pulses after edges 12000 and 2400.
- Runtime change: ch1 running at 2400, write 100 at cnt=500 → the current period completes at 2400 cycles, then periods are 100. Writing 50 then 60 before the wrap → next period is 60.
- Rejected writes: wr_div=0 on ch0, and wr_chan=5 with CHANNELS=2 → wr_err pulses once per write; tick periods are unchanged.
- sync: channels at div 7 and 3, assert sync for 1 cycle → both ticks are 0 in that cycle. Next ticks occur 7 and 3 cycles after release, and coincide every 21 cycles.
- Enable/div=1: div=1 → tick stuck high. Drop en → tick=0 next cycle. Re-enable → first tick after div cycles.
- Async reset mid-count: pull rst_n low with no clock edge → tick, wr_err (and sq) are 0 immediately, and divisors revert to DEF_DIV.
